// File: rtl/wrd_pkg.sv
// Shared types and default sizes for the wrd conv1d pipeline.
package wrd_pkg;

  localparam int BW          = 8;
  localparam int FRAME_LEN   = 50;
  localparam int NUM_FILTERS = 8;
  localparam int T_BW        = $clog2(FRAME_LEN);
  localparam int F_BW        = $clog2(NUM_FILTERS);

  typedef enum logic {FILL, DRAIN} state_t;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_transposer_mem.sv
// Frame buffer: one scalar write port at (t, f), one full-row read port at t.
module transpose_mem #(
  parameter int BW          = wrd_pkg::BW,
  parameter int FRAME_LEN   = wrd_pkg::FRAME_LEN,
  parameter int NUM_FILTERS = wrd_pkg::NUM_FILTERS,
  parameter int TW          = wrd_pkg::T_BW,
  parameter int FW          = wrd_pkg::F_BW
) (
  input  logic                             clk_i,
  input  logic                             wr_en,
  input  logic [TW-1:0]                    wr_t,
  input  logic [FW-1:0]                    wr_f,
  input  logic [BW-1:0]                    wr_data,
  input  logic [TW-1:0]                    rd_t,
  output logic [NUM_FILTERS-1:0][BW-1:0]   rd_row
);
  import wrd_pkg::*;

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
    logic [BW-1:0] lane_mem [FRAME_LEN];

    always_ff @(posedge clk_i) begin
      if (wr_en && wr_f == FW'(f)) lane_mem[wr_t] <= wr_data;
    end

    assign rd_row[f] = lane_mem[rd_t];
  end

endmodule

// File: rtl/frame_transposer.sv
// Re-orders a filter-major scalar stream into time-major column vectors,
// one whole frame at a time (fill, then drain).
module frame_transposer #(
  parameter int BW          = wrd_pkg::BW,
  parameter int FRAME_LEN   = wrd_pkg::FRAME_LEN,
  parameter int NUM_FILTERS = wrd_pkg::NUM_FILTERS
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [BW-1:0]               data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [NUM_FILTERS*BW-1:0]   data_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic                        err_o
);
  import wrd_pkg::*;

  localparam int TW = cnt_w(FRAME_LEN);
  localparam int FW = cnt_w(NUM_FILTERS);
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);

  state_t state, state_nxt;

  logic [TW-1:0] wr_t, rd_t, last_t;
  logic [FW-1:0] wr_f, last_f;
  logic          wr_en, full, load, out_done;

  logic [NUM_FILTERS-1:0][BW-1:0] row, row_masked;

  assign full = (wr_t == T_LAST) && (wr_f == F_LAST);

  always_ff @(posedge clk_i) begin
    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    wr_en     = 1'b0;
    load      = 1'b0;
    out_done  = 1'b0;
    case (state)
      FILL: begin
        ready_o = !rst_i;
        wr_en   = valid_i && ready_o;
        if (wr_en && (last_i || full)) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_done = valid_o && ready_i && last_o;
        load     = !out_done && (!valid_o || ready_i);
        if (out_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    if (rst_i) state_nxt = FILL;
  end

  // Write side: nested (t, f) counters; the frame end position is kept so
  // the drain can blank entries that were never written this frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_t    <= '0;
      wr_f    <= '0;
      last_t  <= '0;
      last_f  <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (wr_en) begin
        if (last_i || full) begin
          wr_t   <= '0;
          wr_f   <= '0;
          last_t <= wr_t;
          last_f <= wr_f;
          err_o  <= last_i ^ full;
        end else if (wr_t == T_LAST) begin
          wr_t <= '0;
          wr_f <= wr_f + 1'b1;
        end else begin
          wr_t <= wr_t + 1'b1;
        end
      end
    end
  end

  transpose_mem #(
    .BW          (BW),
    .FRAME_LEN   (FRAME_LEN),
    .NUM_FILTERS (NUM_FILTERS),
    .TW          (TW),
    .FW          (FW)
  ) u_mem (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_t    (wr_t),
    .wr_f    (wr_f),
    .wr_data (data_i),
    .rd_t    (rd_t),
    .rd_row  (row)
  );

  // Entry (t, f) holds this frame's data iff it precedes or equals the end position.
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_mask
    localparam logic [FW-1:0] FI = FW'(f);
    assign row_masked[f] = ((FI < last_f) || (FI == last_f && rd_t <= last_t)) ? row[f] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_t    <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else if (out_done) begin
      rd_t    <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (load) begin
      data_o  <= row_masked;
      valid_o <= 1'b1;
      last_o  <= (rd_t == T_LAST);
      rd_t    <= (rd_t == T_LAST) ? '0 : rd_t + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_transposer.sv
// Directed bench for frame_transposer: 4x3 instance for the scenarios, 50x8 for one frame.
module tb_frame_transposer;
  localparam int FL = 4;
  localparam int NF = 3;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, valid_i, last_i, ready_i;
  logic [BW-1:0]     data_i;
  logic              ready_o, valid_o, last_o, err_o;
  logic [NF*BW-1:0]  data_o;

  logic              valid2, last2, ready2;
  logic [7:0]        data2;
  logic              ready_o2, valid_o2, last_o2, err_o2;
  logic [63:0]       data_o2;

  frame_transposer #(.BW(BW), .FRAME_LEN(FL), .NUM_FILTERS(NF)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .ready_i(ready_i), .err_o(err_o));

  frame_transposer dut2 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data2), .valid_i(valid2), .last_i(last2),
    .ready_o(ready_o2), .data_o(data_o2), .valid_o(valid_o2), .last_o(last_o2),
    .ready_i(ready2), .err_o(err_o2));

  int passes = 0;
  int total  = 0;

  int cyc = 0, err_cnt = 0, stall_bad = 0, drain_rdy_bad = 0;
  int lastx_cyc = -1, rise_cyc = -1;
  logic rdy_mode = 1'b0;
  logic [NF*BW:0] outq [$];
  logic pv_stall = 1'b0, prev_rdy = 1'b0, plast = 1'b0;
  logic [NF*BW-1:0] pdata = '0;

  // Downstream ready: always 1, or the 1,0,0 backpressure pattern.
  initial begin
    int rk;
    rk = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        ready_i = (rk % 3 == 0);
        rk++;
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  // Output monitor: records accepted vectors and interface events.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (err_o) err_cnt++;
      if (valid_o && ready_o) drain_rdy_bad++;
      if (pv_stall && (valid_o !== 1'b1 || data_o !== pdata || last_o !== plast)) stall_bad++;
      pv_stall = valid_o && !ready_i;
      pdata    = data_o;
      plast    = last_o;
      if (valid_o && ready_i) begin
        outq.push_back({last_o, data_o});
        if (last_o) lastx_cyc = cyc;
      end
      if (ready_o && !prev_rdy) rise_cyc = cyc;
      prev_rdy = ready_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    step();
    data_i  = d;
    valid_i = 1'b1;
    last_i  = l;
    for (int k = 0; k < 100 && !ready_o; k++) step();
    chk("send_ready", ready_o, 1);
    @(posedge clk);
  endtask

  // Scalars n0..n1-1 of a frame, value off+f*16+t; last_i on 1-based index last_n.
  task automatic send_frame(input logic [7:0] off, input int last_n, input int n0, input int n1);
    for (int n = n0; n < n1; n++)
      send(off + 8'((n / FL) * 16 + (n % FL)), (n + 1 == last_n));
  endtask

  task automatic idle();
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int k = 0; k < 200 && outq.size() < n; k++) step();
    chk(tag, (outq.size() >= n), 1);
  endtask

  task automatic expect_vecs(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] ev [4];
    logic [NF*BW:0] got;
    ev = '{e0, e1, e2, e3};
    wait_out({tag, "_cnt"}, 4);
    for (int i = 0; i < 4; i++) begin
      got = (outq.size() > 0) ? outq.pop_front() : '1;
      chk({tag, "_data"}, got[NF*BW-1:0], ev[i]);
      chk({tag, "_last"}, got[NF*BW], (i == 3));
    end
  endtask

  function automatic logic [7:0] val2(input int f, input int t);
    return 8'((f * 37 + t * 3) & 255);
  endfunction

  initial begin
    int e;
    int vcnt;
    logic [63:0] ev2;

    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
    valid2 = 1'b0; last2 = 1'b0; data2 = '0; ready2 = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 0);
    rst_i = 1'b0;
    step();
    chk("post_rst_ready", ready_o, 1);

    // 1: nominal frame, latency 2
    e = err_cnt;
    send_frame(8'h00, 12, 0, 12);
    idle();
    chk("lat_c1_valid", valid_o, 0);
    chk("lat_c1_ready", ready_o, 0);
    step();
    chk("lat_c2_valid", valid_o, 1);
    expect_vecs("nom", 24'h201000, 24'h211101, 24'h221202, 24'h231303);
    chk("nom_err", err_cnt - e, 0);

    // 2: backpressure
    rdy_mode = 1'b1;
    stall_bad = 0; drain_rdy_bad = 0;
    send_frame(8'h00, 12, 0, 12);
    idle();
    expect_vecs("bp", 24'h201000, 24'h211101, 24'h221202, 24'h231303);
    step(); step(); step();
    chk("bp_extra", outq.size(), 0);
    chk("bp_stall_stable", stall_bad, 0);
    chk("bp_ready_in_drain", drain_rdy_bad, 0);
    rdy_mode = 1'b0;
    step(); step();

    // 3: early last on scalar #6 (f=1, t=1)
    e = err_cnt;
    send_frame(8'h00, 6, 0, 6);
    idle();
    expect_vecs("early", 24'h001000, 24'h001101, 24'h000002, 24'h000003);
    chk("early_err", err_cnt - e, 1);

    // 4: missing last
    e = err_cnt;
    send_frame(8'h00, 0, 0, 12);
    idle();
    chk("miss_ready_drop", ready_o, 0);
    expect_vecs("miss", 24'h201000, 24'h211101, 24'h221202, 24'h231303);
    chk("miss_err", err_cnt - e, 1);

    // 5: back-to-back frames, second frame carries 0x80..0xA3
    e = err_cnt;
    send_frame(8'h00, 12, 0, 12);
    send_frame(8'h80, 12, 0, 1);
    chk("b2b_rise", rise_cyc, lastx_cyc + 1);
    send_frame(8'h80, 12, 1, 12);
    idle();
    wait_out("b2b_cnt8", 8);
    expect_vecs("b2b_f1", 24'h201000, 24'h211101, 24'h221202, 24'h231303);
    expect_vecs("b2b_f2", 24'hA09080, 24'hA19181, 24'hA29282, 24'hA39383);
    chk("b2b_err", err_cnt - e, 0);

    // 6: reset after the 2nd vector
    e = err_cnt;
    send_frame(8'h00, 12, 0, 12);
    idle();
    for (int k = 0; k < 100 && outq.size() < 2; k++) step();
    rst_i = 1'b1;
    step();
    chk("mrst_valid", valid_o, 0);
    chk("mrst_ready", ready_o, 0);
    step();
    chk("mrst_valid2", valid_o, 0);
    rst_i = 1'b0;
    step();
    chk("mrst_ready_after", ready_o, 1);
    step(); step(); step();
    chk("mrst_no_more_out", outq.size(), 2);
    chk("mrst_err", err_cnt - e, 0);
    outq.delete();
    send_frame(8'h00, 12, 0, 12);
    idle();
    expect_vecs("mrst_next", 24'h201000, 24'h211101, 24'h221202, 24'h231303);

    // Default 50x8 instance, one nominal frame
    chk("def_ready", ready_o2, 1);
    for (int n = 0; n < 400; n++) begin
      step();
      data2  = val2(n / 50, n % 50);
      valid2 = 1'b1;
      last2  = (n == 399);
      @(posedge clk);
    end
    step();
    valid2 = 1'b0;
    last2  = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 100 && vcnt < 50; k++) begin
      step();
      if (valid_o2) begin
        for (int f = 0; f < 8; f++) ev2[f*8 +: 8] = val2(f, vcnt);
        chk("def_data", data_o2, ev2);
        chk("def_last", last_o2, (vcnt == 49));
        vcnt++;
      end
    end
    chk("def_vec_cnt", vcnt, 50);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
